// File: rtl/imem_loader.sv
// Byte-stream loader for the RV32I instruction memory write port.
// Parses a LEN/payload/CSUM frame and holds the core in reset while loading.
module imem_loader #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [31:0]       wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              cpu_rst_n
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN0,
      S_LEN1,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [16:0] DEPTH_L = 17'(DEPTH);

   state_t      state;
   state_t      state_nx;

   logic [7:0]  len_lo;
   logic [15:0] len;
   logic [1:0]  bcnt;
   logic [15:0] widx;
   logic [23:0] asm_q;
   logic [7:0]  csum;

   logic        xfer;
   logic        last_word;
   logic [16:0] len_rx;

   assign xfer      = in_valid && in_ready;
   assign len_rx    = {1'b0, in_data, len_lo};
   assign last_word = (widx == (len - 16'd1));

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_nx = S_LEN0;
            end
         end
         S_LEN0: begin
            if (xfer) begin
               state_nx = S_LEN1;
            end
         end
         S_LEN1: begin
            if (xfer) begin
               if (len_rx > DEPTH_L) begin
                  state_nx = S_ERR;
               end else if (len_rx == '0) begin
                  state_nx = S_CSUM;
               end else begin
                  state_nx = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (xfer && (bcnt == 2'd3) && last_word) begin
               state_nx = S_CSUM;
            end
         end
         S_CSUM: begin
            if (xfer) begin
               state_nx = (in_data == csum) ? S_DONE : S_ERR;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Status outputs decoded from the state
   always_comb begin
      in_ready  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      cpu_rst_n = 1'b1;
      case (state)
         S_LEN0, S_LEN1, S_DATA, S_CSUM: begin
            in_ready  = 1'b1;
            busy      = 1'b1;
            cpu_rst_n = 1'b0;
         end
         S_DONE: begin
            done = 1'b1;
         end
         S_ERR: begin
            err       = 1'b1;
            cpu_rst_n = 1'b0;
         end
         default: begin
            in_ready  = 1'b0;
         end
      endcase
   end

   // Datapath: the first three bytes of a word shift in from the top so the
   // fourth byte completes {b3,b2,b1,b0} without a separate byte-lane mux.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         len_lo <= '0;
         len    <= '0;
         bcnt   <= '0;
         widx   <= '0;
         asm_q  <= '0;
         csum   <= '0;
         we     <= 1'b0;
         waddr  <= '0;
         wdata  <= '0;
      end else begin
         we <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  bcnt  <= '0;
                  widx  <= '0;
                  asm_q <= '0;
                  csum  <= '0;
               end
            end
            S_LEN0: begin
               if (xfer) begin
                  len_lo <= in_data;
               end
            end
            S_LEN1: begin
               if (xfer) begin
                  len <= {in_data, len_lo};
               end
            end
            S_DATA: begin
               if (xfer) begin
                  csum <= csum ^ in_data;
                  bcnt <= bcnt + 2'd1;
                  if (bcnt == 2'd3) begin
                     we    <= 1'b1;
                     waddr <= widx[ADDR_W-1:0];
                     wdata <= {in_data, asm_q};
                     widx  <= widx + 16'd1;
                  end else begin
                     asm_q <= {in_data, asm_q[23:8]};
                  end
               end
            end
            default: begin
               len_lo <= len_lo;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized frames
// with byte gaps, compared against a frame-parsing reference model.
module tb_imem_loader;

   localparam int DEPTH  = 256;
   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [31:0]       wdata;
   logic              busy;
   logic              done;
   logic              err;
   logic              cpu_rst_n;

   imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .cpu_rst_n (cpu_rst_n)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [ADDR_W-1:0] obs_addr[$];
   logic [31:0]       obs_data[$];
   byte unsigned      tx[$];
   logic [31:0]       ew[$];
   bit                exp_done;

   // Write-port monitor
   always @(negedge clk) begin
      if (we === 1'b1) begin
         obs_addr.push_back(waddr);
         obs_data.push_back(wdata);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: parse the frame as a host would and predict the writes
   // and final status.
   task automatic model_frame();
      int n;
      byte unsigned x;
      n = int'(tx[0]) | (int'(tx[1]) << 8);
      ew.delete();
      exp_done = 1'b0;
      if (n > DEPTH) return;
      x = 8'h00;
      for (int i = 0; i < n; i++) begin
         logic [31:0] w;
         w = 32'(tx[2+4*i]) + (32'(tx[3+4*i]) << 8) + (32'(tx[4+4*i]) << 16) + (32'(tx[5+4*i]) << 24);
         ew.push_back(w);
         for (int k = 0; k < 4; k++) x = x ^ tx[2+4*i+k];
      end
      exp_done = (tx[2+4*n] == x);
   endtask

   task automatic build_frame(input int n, input bit bad);
      byte unsigned x;
      tx.delete();
      tx.push_back(8'(n));
      tx.push_back(8'(n >> 8));
      if (n > DEPTH) return;
      x = 8'h00;
      for (int i = 0; i < 4 * n; i++) begin
         byte unsigned b;
         b = 8'($urandom);
         tx.push_back(b);
         x = x ^ b;
      end
      if (bad) x = x ^ 8'($urandom_range(1, 255));
      tx.push_back(x);
   endtask

   task automatic send_byte(input byte unsigned b, input int gap);
      int t;
      t = 0;
      forever begin
         @(negedge clk);
         if (int'($urandom_range(0, 99)) < gap) begin
            in_valid = 1'b0;
         end else begin
            in_valid = 1'b1;
            in_data  = b;
            if (in_ready === 1'b1) return;
         end
         t++;
         if (t > 2000) begin
            check("send_timeout", 32'd0, 32'd1);
            return;
         end
      end
   endtask

   task automatic send_range(input int lo, input int hi, input int gap);
      for (int i = lo; i < hi; i++) send_byte(tx[i], gap);
   endtask

   task automatic start_load(input string tag);
      obs_addr.delete();
      obs_data.delete();
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_cpurst"}, 32'(cpu_rst_n), 32'd0);
   endtask

   task automatic finish_frame();
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_outcome(input string tag);
      check({tag, "_done"}, 32'(done), 32'(exp_done));
      check({tag, "_err"}, 32'(err), 32'(!exp_done));
      check({tag, "_cpurst"}, 32'(cpu_rst_n), 32'(exp_done));
      check({tag, "_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_nwr"}, 32'(obs_addr.size()), 32'(ew.size()));
      for (int i = 0; i < ew.size() && i < obs_addr.size(); i++) begin
         check($sformatf("%s_addr%0d", tag, i), 32'(obs_addr[i]), 32'(i));
         check($sformatf("%s_data%0d", tag, i), obs_data[i], ew[i]);
      end
   endtask

   task automatic run_frame(input string tag, input int gap);
      model_frame();
      start_load(tag);
      send_range(0, tx.size(), gap);
      finish_frame();
      check_outcome(tag);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_we"}, 32'(we), 32'd0);
      check({tag, "_waddr"}, 32'(waddr), 32'd0);
      check({tag, "_wdata"}, wdata, 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_err"}, 32'(err), 32'd0);
      check({tag, "_cpurst"}, 32'(cpu_rst_n), 32'd1);
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(negedge clk);
      check_reset("rst");
      rst_n = 1'b1;

      // Good 2-word image from the plan, full rate
      tx = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
      run_frame("good2", 0);
      check("good2_w0_literal", obs_data.size() > 0 ? obs_data[0] : 32'hx, 32'h0000_0013);
      check("good2_w1_literal", obs_data.size() > 1 ? obs_data[1] : 32'hx, 32'h0010_0093);

      // Checksum mismatch, then recovery with the good frame
      tx = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h91};
      run_frame("badcs", 0);
      tx = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
      run_frame("recover", 0);

      // Oversize length N=257
      tx = {8'h01, 8'h01};
      run_frame("oversize", 0);

      // Zero length, good and bad checksum
      tx = {8'h00, 8'h00, 8'h00};
      run_frame("zero_ok", 0);
      tx = {8'h00, 8'h00, 8'h01};
      run_frame("zero_bad", 0);

      // Full-depth image with random source gaps
      build_frame(DEPTH, 1'b0);
      run_frame("full", 30);

      // Random small frames, some corrupt or oversize
      for (int r = 0; r < 12; r++) begin
         int n;
         n = (r == 11) ? DEPTH + 1 + int'($urandom_range(0, 1000)) : int'($urandom_range(0, 9));
         build_frame(n, $urandom_range(0, 1) == 1);
         run_frame($sformatf("rnd%0d", r), int'($urandom_range(0, 50)));
      end

      // start pulsed mid-load is ignored
      build_frame(2, 1'b0);
      model_frame();
      start_load("midstart");
      send_range(0, 5, 20);
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("midstart_busy", 32'(busy), 32'd1);
      send_range(5, tx.size(), 20);
      finish_frame();
      check_outcome("midstart");

      // Reset after 6 payload bytes aborts with one word written
      build_frame(4, 1'b0);
      model_frame();
      start_load("abort");
      send_range(0, 8, 0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);
      check_reset("abort");
      @(negedge clk);
      check("abort_nwr", 32'(obs_addr.size()), 32'd1);
      check("abort_addr0", obs_addr.size() > 0 ? 32'(obs_addr[0]) : 32'hx, 32'd0);
      check("abort_data0", obs_data.size() > 0 ? obs_data[0] : 32'hx, ew[0]);
      rst_n = 1'b1;

      // Loader works again after the abort
      build_frame(3, 1'b0);
      run_frame("post_abort", 10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
